multisim_rw_initiator: RTL and testbench
========================================

Name: multisim_rw_initiator

Overview:
- Command initiator for the cmd/rsp read-write memory protocol; it drives the requester side of a responder that owns a byte-addressed memory.
- A host issues one burst request (read or write, base address, length). The block then sequences the transactions one at a time: cmd handshake, then rsp handshake.
- Writes use an incrementing data pattern. Reads accumulate a checksum and keep the last returned byte.
- Used as the stimulus and checking master in the multisim FSM-extraction tests.

Parameters:
- ADDR_W, 8, width of cmd_address and base_addr
- DATA_W, 8, width of cmd_wdata, rsp_data, wdata_seed, rd_last
- SUM_W, 16, width of rd_sum accumulator
- TIMEOUT_CYCLES, 1024, watchdog limit, used only when MULTISIM_RW_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock; all logic on the posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  burst request, sampled in IDLE only
- op_write  in  1  1 = write burst, 0 = read burst; captured on start
- base_addr  in  ADDR_W  first address; captured on start
- burst_len  in  ADDR_W  number of transactions; 0 = none; captured on start
- wdata_seed  in  DATA_W  write data for index 0; captured on start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at burst end
- err  out  1  timeout flag; constant 0 without the macro
- rd_sum  out  SUM_W  running sum of read rsp_data; cleared on start
- rd_last  out  DATA_W  last read rsp_data
- cmd_vld  out  1  command valid
- cmd_rdy  in  1  responder ready
- cmd_rwb  out  1  1 = read, 0 = write
- cmd_address  out  ADDR_W  command address
- cmd_wdata  out  DATA_W  write data; 0 on reads
- rsp_vld  in  1  response valid
- rsp_rdy  out  1  initiator ready for response
- rsp_data  in  DATA_W  response data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE
  - busy, done, err, cmd_vld, rsp_rdy, cmd_rwb, cmd_address, cmd_wdata = 0
  - rd_sum, rd_last, index = 0
  - Reset mid-burst abandons the burst immediately; no further cmd is issued.
- States: IDLE, CMD, RSP, DONE. All outputs are registered.
- IDLE:
  - start=1 captures the request and clears rd_sum, rd_last, index, err.
  - burst_len≠0: go to CMD; busy and cmd_vld are high the next cycle.
  - burst_len=0: go to DONE; no cmd is issued.
  - start outside IDLE is ignored.
- CMD:
  - cmd_vld=1.
  - cmd_address = base_addr+index, mod 2^ADDR_W (wraps).
  - cmd_rwb = !op_write.
  - cmd_wdata = wdata_seed+index, mod 2^DATA_W (0 on reads).
  - All cmd fields stay stable while cmd_rdy=0.
  - On cmd_vld&cmd_rdy: go to RSP with cmd_vld=0 and rsp_rdy=1 the next cycle.
- RSP:
  - rsp_rdy=1; exactly one transaction is outstanding.
  - On rsp_vld&rsp_rdy: for reads, rd_sum += zero-extended rsp_data (wraps mod 2^SUM_W) and rd_last = rsp_data. For writes, rsp_data is ignored.
  - Then index++. If index == burst_len: go to DONE, else go to CMD. rsp_rdy=0 the next cycle.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is accepted again the following cycle.
- Throughput with a zero-wait responder: 2 cycles per transaction plus response latency.
- rsp_vld while not in RSP is ignored.

Optional Feature:
- Macro: MULTISIM_RW_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to CMD or RSP and increments each cycle spent waiting for a handshake.
  - Reaching TIMEOUT_CYCLES drops cmd_vld/rsp_rdy, sets err=1 (sticky until the next start) and goes to DONE.
  - rd_sum holds the partial result.
- Undefined: no counter is built; err is tied 0 and the FSM waits indefinitely.

Test Plan:
1. Write burst, base=0x10, len=4, seed=0xA0, responder always ready, rsp after 1 cycle -> cmds at addr 0x10..0x13 with wdata 0xA0..0xA3, cmd_rwb=0, a single done pulse, busy low after.
2. Read burst of the same range from a memory holding 0xA0..0xA3 -> rd_sum=0x0286, rd_last=0xA3, cmd_rwb=1, cmd_wdata=0.
3. Wrap: write base=0xFE, len=3, seed=0xFF -> addr FE,FF,00 with wdata FF,00,01.
4. Backpressure: cmd_rdy low 5 cycles, then rsp_vld delayed 7 cycles -> cmd fields stable throughout; exactly one cmd handshake and one rsp handshake per index; start pulses while busy are ignored.
5. len=0 -> done one cycle after start; cmd_vld never asserted; rd_sum=0. Also: reset asserted in RSP mid-burst -> all outputs 0 immediately, and a new burst after reset starts at index 0.
6. With MULTISIM_RW_TIMEOUT_EN and TIMEOUT_CYCLES=16, rsp_vld never asserted -> err=1 and done after 16 RSP cycles, rsp_rdy drops; without the macro -> busy stays 1 and err=0.

Source files
------------

// File: rtl/multisim_rw_initiator.sv
// rtl/multisim_rw_initiator.sv - burst cmd/rsp initiator; optional watchdog under MULTISIM_RW_TIMEOUT_EN
module multisim_rw_initiator #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int SUM_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_write,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] burst_len,
   input  logic [DATA_W-1:0] wdata_seed,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [SUM_W-1:0]  rd_sum,
   output logic [DATA_W-1:0] rd_last,
   output logic              cmd_vld,
   input  logic              cmd_rdy,
   output logic              cmd_rwb,
   output logic [ADDR_W-1:0] cmd_address,
   output logic [DATA_W-1:0] cmd_wdata,
   input  logic              rsp_vld,
   output logic              rsp_rdy,
   input  logic [DATA_W-1:0] rsp_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Burst request captured at start; the live inputs are free to change afterwards.
   logic              op_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [DATA_W-1:0] seed_q;
   logic [ADDR_W-1:0] index, index_nxt;

   logic              capture;
   logic              eff_op;
   logic [ADDR_W-1:0] eff_base;
   logic [DATA_W-1:0] eff_seed;
   logic [SUM_W-1:0]  sum_nxt;
   logic [DATA_W-1:0] last_nxt;
   logic              err_nxt;
   logic              rwb_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;

`ifdef MULTISIM_RW_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next values of every registered output and counter.
   always_comb begin
      state_nxt = state;
      index_nxt = index;
      sum_nxt   = rd_sum;
      last_nxt  = rd_last;
`ifdef MULTISIM_RW_TIMEOUT_EN
      err_nxt   = err;
      wait_nxt  = wait_cnt;
`else
      err_nxt   = 1'b0;
`endif
      capture   = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               capture   = 1'b1;
               index_nxt = '0;
               sum_nxt   = '0;
               last_nxt  = '0;
               err_nxt   = 1'b0;
               state_nxt = (burst_len != '0) ? S_CMD : S_DONE;
            end
         end
         S_CMD: begin
            if (cmd_rdy) begin
               state_nxt = S_RSP;
            end
`ifdef MULTISIM_RW_TIMEOUT_EN
            else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
`endif
         end
         S_RSP: begin
            if (rsp_vld) begin
               if (!op_q) begin
                  sum_nxt  = rd_sum + SUM_W'(rsp_data);
                  last_nxt = rsp_data;
               end
               index_nxt = index + ADDR_W'(1);
               state_nxt = (index_nxt == len_q) ? S_DONE : S_CMD;
            end
`ifdef MULTISIM_RW_TIMEOUT_EN
            else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
`endif
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

`ifdef MULTISIM_RW_TIMEOUT_EN
      // Every entry into CMD or RSP starts a fresh wait window.
      if (state_nxt != state) begin
         wait_nxt = '0;
      end
`endif

      // On the accepting cycle the request comes straight from the inputs.
      eff_op   = capture ? op_write   : op_q;
      eff_base = capture ? base_addr  : base_q;
      eff_seed = capture ? wdata_seed : seed_q;

      rwb_nxt   = cmd_rwb;
      addr_nxt  = cmd_address;
      wdata_nxt = cmd_wdata;
      if (state_nxt == S_CMD) begin
         rwb_nxt   = !eff_op;
         addr_nxt  = eff_base + index_nxt;
         wdata_nxt = eff_op ? (eff_seed + DATA_W'(index_nxt)) : '0;
      end
   end

   // Registered outputs, captured request and transaction index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         cmd_vld     <= 1'b0;
         rsp_rdy     <= 1'b0;
         cmd_rwb     <= 1'b0;
         cmd_address <= '0;
         cmd_wdata   <= '0;
         rd_sum      <= '0;
         rd_last     <= '0;
         index       <= '0;
         op_q        <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         seed_q      <= '0;
      end else begin
         busy        <= (state_nxt == S_CMD) || (state_nxt == S_RSP);
         done        <= (state_nxt == S_DONE);
         cmd_vld     <= (state_nxt == S_CMD);
         rsp_rdy     <= (state_nxt == S_RSP);
         err         <= err_nxt;
         cmd_rwb     <= rwb_nxt;
         cmd_address <= addr_nxt;
         cmd_wdata   <= wdata_nxt;
         rd_sum      <= sum_nxt;
         rd_last     <= last_nxt;
         index       <= index_nxt;
         if (capture) begin
            op_q   <= op_write;
            base_q <= base_addr;
            len_q  <= burst_len;
            seed_q <= wdata_seed;
         end
      end
   end

`ifdef MULTISIM_RW_TIMEOUT_EN
   // Handshake wait counter for the watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_multisim_rw_initiator.sv
// tb/tb_multisim_rw_initiator.sv - randomized self-checking bench for multisim_rw_initiator
module tb_multisim_rw_initiator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       op_write;
   logic [7:0] base_addr;
   logic [7:0] burst_len;
   logic [7:0] wdata_seed;
   logic       busy;
   logic       done;
   logic       err;
   logic [15:0] rd_sum;
   logic [7:0] rd_last;
   logic       cmd_vld;
   logic       cmd_rdy;
   logic       cmd_rwb;
   logic [7:0] cmd_address;
   logic [7:0] cmd_wdata;
   logic       rsp_vld;
   logic       rsp_rdy;
   logic [7:0] rsp_data;

   int n_checks = 0;
   int n_err    = 0;

   // Responder memory, and the bench's own burst-level picture of it.
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   int         cmd_wait;
   int         rsp_lat;
   bit         rsp_never;
   bit         spurious;
   int         cmd_stall;
   int         lat_cnt;
   bit         pending;
   logic [7:0] pend_data;
   bit         cmd_hs;
   bit         rsp_hs;
   logic [7:0] hs_addr;
   logic [7:0] hs_wdata;
   logic       hs_rwb;
   bit         prev_vld;
   bit         prev_hs;
   logic [7:0] prev_addr;
   logic [7:0] prev_wdata;
   logic       prev_rwb;

   logic [7:0] q_addr  [$];
   logic [7:0] q_wdata [$];
   logic       q_rwb   [$];
   int         rsp_hs_cnt;
   int         done_cnt;
   int         vld_seen;
   int         unstable;

   multisim_rw_initiator #(
      .ADDR_W(8), .DATA_W(8), .SUM_W(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_write(op_write),
      .base_addr(base_addr), .burst_len(burst_len), .wdata_seed(wdata_seed),
      .busy(busy), .done(done), .err(err), .rd_sum(rd_sum), .rd_last(rd_last),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_rwb(cmd_rwb),
      .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Responder: acts on the handshakes of the previous posedge, then drives the next cycle.
   initial begin
      cmd_rdy = 1'b0;
      rsp_vld = 1'b0;
      rsp_data = 8'h00;
      pending = 1'b0;
      cmd_hs = 1'b0;
      rsp_hs = 1'b0;
      prev_vld = 1'b0;
      prev_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cmd_rdy = 1'b0;
            rsp_vld = 1'b0;
            pending = 1'b0;
            cmd_hs = 1'b0;
            rsp_hs = 1'b0;
            prev_vld = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (cmd_vld) vld_seen++;
            if (prev_vld && !prev_hs &&
                (!cmd_vld || cmd_address !== prev_addr || cmd_rwb !== prev_rwb || cmd_wdata !== prev_wdata))
               unstable++;
            if (rsp_hs) begin
               rsp_hs_cnt++;
               pending = 1'b0;
               rsp_vld = 1'b0;
            end
            if (cmd_hs) begin
               q_addr.push_back(hs_addr);
               q_rwb.push_back(hs_rwb);
               q_wdata.push_back(hs_wdata);
               if (!hs_rwb) mem[hs_addr] = hs_wdata;
               pend_data = hs_rwb ? mem[hs_addr] : 8'($urandom);
               pending = 1'b1;
               lat_cnt = rsp_lat;
               cmd_rdy = 1'b0;
               cmd_stall = cmd_wait;
               rsp_vld = 1'b0;
            end else if (cmd_vld && !cmd_rdy) begin
               if (cmd_stall > 0) cmd_stall--;
               else cmd_rdy = 1'b1;
            end
            if (pending) begin
               if (!rsp_vld && !rsp_never) begin
                  if (lat_cnt > 0) lat_cnt--;
                  else begin
                     rsp_vld = 1'b1;
                     rsp_data = pend_data;
                  end
               end
            end else begin
               rsp_vld = spurious && ($urandom_range(0, 1) == 1);
               rsp_data = 8'($urandom);
            end
            prev_vld = cmd_vld;
            prev_addr = cmd_address;
            prev_rwb = cmd_rwb;
            prev_wdata = cmd_wdata;
            cmd_hs = cmd_vld && cmd_rdy;
            hs_addr = cmd_address;
            hs_rwb = cmd_rwb;
            hs_wdata = cmd_wdata;
            prev_hs = cmd_hs;
            rsp_hs = rsp_vld && rsp_rdy;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_burst(input bit op, input logic [7:0] base, input logic [7:0] len,
                            input logic [7:0] seed, input int cw, input int lat,
                            input bit spur, input bit noise_start, input string name);
      logic [15:0] exp_sum;
      logic [7:0]  exp_last;
      logic [7:0]  a;
      logic [7:0]  w;
      bit          got;
      cmd_wait = cw;
      rsp_lat = lat;
      spurious = spur;
      rsp_never = 1'b0;
      cmd_stall = cw;
      q_addr.delete();
      q_rwb.delete();
      q_wdata.delete();
      rsp_hs_cnt = 0;
      done_cnt = 0;
      vld_seen = 0;
      unstable = 0;
      op_write = op;
      base_addr = base;
      burst_len = len;
      wdata_seed = seed;
      start = 1'b1;
      step();
      start = 1'b0;
      if (len == 8'd0) check({name, "_first_busy_done"}, {30'b0, busy, done}, 32'h1);
      else check({name, "_first_busy_vld"}, {30'b0, busy, cmd_vld}, 32'h3);
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done_cnt > 0) begin
            got = 1'b1;
            break;
         end
         if (noise_start && busy) begin
            start = ($urandom_range(0, 1) == 1);
            op_write = 1'($urandom);
            base_addr = 8'($urandom);
            burst_len = 8'($urandom);
            wdata_seed = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      check({name, "_done_seen"}, {31'b0, got}, 32'h1);
      step();
      check({name, "_after_busy_done"}, {30'b0, busy, done}, 32'h0);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_cmd_count"}, q_addr.size(), {24'b0, len});
      check({name, "_rsp_count"}, rsp_hs_cnt, {24'b0, len});
      check({name, "_stable"}, unstable, 0);
      check({name, "_err"}, {31'b0, err}, 32'h0);
      if (len == 8'd0) check({name, "_no_cmd_vld"}, vld_seen, 0);
      exp_sum = 16'h0;
      exp_last = 8'h0;
      for (int i = 0; i < int'(len); i++) begin
         a = base + 8'(i);
         w = op ? seed + 8'(i) : 8'h00;
         if (i < q_addr.size())
            check($sformatf("%s_cmd%0d", name, i), {8'b0, q_addr[i], 7'b0, q_rwb[i], q_wdata[i]},
                  {8'b0, a, 7'b0, !op, w});
         if (op) ref_mem[a] = w;
         else begin
            exp_sum = exp_sum + {8'h00, ref_mem[a]};
            exp_last = ref_mem[a];
         end
      end
      check({name, "_rd_sum"}, {16'b0, rd_sum}, {16'b0, exp_sum});
      check({name, "_rd_last"}, {24'b0, rd_last}, {24'b0, exp_last});
   endtask

   initial begin
      bit         seen;
      int         rdy_cycles;
      logic [7:0] v;
      rst_n = 1'b0;
      start = 1'b0;
      op_write = 1'b0;
      base_addr = 8'h00;
      burst_len = 8'h00;
      wdata_seed = 8'h00;
      cmd_wait = 0;
      rsp_lat = 0;
      rsp_never = 1'b0;
      spurious = 1'b0;
      cmd_stall = 0;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         mem[i] = v;
         ref_mem[i] = v;
      end
      step();
      step();
      check("reset_outputs", {busy, done, err, cmd_vld, rsp_rdy, cmd_rwb, cmd_address, cmd_wdata, rd_sum[5:0], 2'b0},
            32'h0);
      check("reset_sum_last", {8'b0, rd_sum, rd_last}, 32'h0);
      rst_n = 1'b1;
      step();

      run_burst(1'b1, 8'h10, 8'd4, 8'hA0, 0, 1, 1'b0, 1'b0, "t1_write");
      run_burst(1'b0, 8'h10, 8'd4, 8'h00, 0, 1, 1'b0, 1'b0, "t2_read");
      check("t2_sum_const", {16'b0, rd_sum}, 32'h0286);
      check("t2_last_const", {24'b0, rd_last}, 32'hA3);
      run_burst(1'b1, 8'hFE, 8'd3, 8'hFF, 0, 1, 1'b1, 1'b0, "t3_wrap");
      run_burst(1'b1, 8'h30, 8'd3, 8'h55, 5, 7, 1'b1, 1'b1, "t4_bp_write");
      run_burst(1'b0, 8'h30, 8'd3, 8'h00, 5, 7, 1'b1, 1'b1, "t4_bp_read");
      run_burst(1'b0, 8'h22, 8'd0, 8'h77, 0, 0, 1'b1, 1'b0, "t5_len0");

      // Reset while a read response is outstanding.
      cmd_wait = 0;
      rsp_lat = 10;
      spurious = 1'b0;
      cmd_stall = 0;
      op_write = 1'b0;
      base_addr = 8'h40;
      burst_len = 8'd4;
      start = 1'b1;
      step();
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (rsp_rdy) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check("t5_reached_rsp", {31'b0, seen}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("t5_reset_mid_outputs", {busy, done, err, cmd_vld, rsp_rdy, cmd_rwb, cmd_address, cmd_wdata, 10'b0},
            32'h0);
      check("t5_reset_mid_sum_last", {8'b0, rd_sum, rd_last}, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (cmd_vld || busy) seen = 1'b1;
      end
      check("t5_no_cmd_after_reset", {31'b0, seen}, 32'h0);
      run_burst(1'b0, 8'h40, 8'd2, 8'h00, 1, 0, 1'b0, 1'b0, "t5_after_reset");

      // Responder that never answers.
      cmd_wait = 0;
      rsp_lat = 0;
      cmd_stall = 0;
      spurious = 1'b0;
      rsp_never = 1'b1;
      done_cnt = 0;
      op_write = 1'b0;
      base_addr = 8'h00;
      burst_len = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
`ifdef MULTISIM_RW_TIMEOUT_EN
      rdy_cycles = 0;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (rsp_rdy) rdy_cycles++;
         step();
      end
      check("t6_timeout_done", {31'b0, seen}, 32'h1);
      check("t6_rsp_rdy_cycles", rdy_cycles, 16);
      check("t6_err_rdy_busy", {29'b0, err, rsp_rdy, busy}, 32'h4);
      check("t6_partial_sum", {16'b0, rd_sum}, 32'h0);
      step();
      check("t6_err_sticky", {31'b0, err}, 32'h1);
`else
      for (int c = 0; c < 40; c++) step();
      rdy_cycles = done_cnt;
      check("t6_hang_busy_err_rdy", {29'b0, busy, err, rsp_rdy}, 32'h5);
      check("t6_hang_no_done", rdy_cycles, 0);
`endif
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rsp_never = 1'b0;
      step();

      for (int r = 0; r < 10; r++) begin
         run_burst(1'($urandom), 8'($urandom), 8'($urandom_range(1, 8)), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'($urandom),
                   $sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
